// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 pin receiver that reassembles shifted rows and replays them as pixel writes
module hub75_capture #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int COL_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           in_rgb0,
    input  logic [2:0]           in_rgb1,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic                 in_blank,
    input  logic                 in_latch,
    input  logic                 in_sclk,
    output logic                 wr_en,
    output logic                 wr_half,
    output logic [ADDR_BITS-1:0] wr_row,
    output logic [COL_BITS-1:0]  wr_col,
    output logic [2:0]           wr_rgb,
    output logic                 row_done,
    output logic                 frame_done,
    output logic                 panel_blank,
    output logic                 count_err,
    output logic                 overrun
);

    localparam int CNT_BITS = COL_BITS + 1;
    localparam int SYNC_W   = 6 + ADDR_BITS + 3;
    localparam logic [CNT_BITS-1:0] W_CNT    = CNT_BITS'(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(2 * WIDTH - 1);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    // All pins travel as one vector so every bit sees the same synchronizer delay
    logic [SYNC_W-1:0] pins, sync1, sync2;
    logic sclk_prev, latch_prev;

    logic [2:0]           s_rgb0, s_rgb1;
    logic [ADDR_BITS-1:0] s_addr;
    logic                 s_blank, s_latch, s_sclk;
    logic                 sclk_rise, latch_rise;

    assign pins = {in_rgb1, in_rgb0, in_addr, in_blank, in_latch, in_sclk};
    assign {s_rgb1, s_rgb0, s_addr, s_blank, s_latch, s_sclk} = sync2;
    assign sclk_rise  = s_sclk & ~sclk_prev;
    assign latch_rise = s_latch & ~latch_prev;

    // Two-flop synchronizer plus previous-sample registers for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sclk_prev  <= 1'b0;
            latch_prev <= 1'b0;
        end else begin
            sync1      <= pins;
            sync2      <= sync1;
            sclk_prev  <= s_sclk;
            latch_prev <= s_latch;
        end
    end

    state_t               state;
    logic [5:0]           cap_buf   [WIDTH];
    logic [5:0]           cap_next  [WIDTH];
    logic [5:0]           drain_buf [WIDTH];
    logic [CNT_BITS-1:0]  shift_cnt, cnt_next;
    logic                 store, accept;

    assign store    = sclk_rise && (shift_cnt < W_CNT);
    assign cnt_next = store ? shift_cnt + CNT_BITS'(1) : shift_cnt;
    assign accept   = latch_rise && (state == IDLE);

    // Capture buffer with this cycle's sample merged in, so a shift coincident with latch lands in the copied row
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cap_next[i] = (store && shift_cnt == CNT_BITS'(i)) ? {s_rgb1, s_rgb0} : cap_buf[i];
        end
    end

    // Column capture on sclk rise; latch clears the row and hands it to the drain buffer when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cap_buf[i]   <= '0;
                drain_buf[i] <= '0;
            end
        end else begin
            shift_cnt <= latch_rise ? '0 : cnt_next;
            for (int i = 0; i < WIDTH; i++) begin
                cap_buf[i] <= latch_rise ? 6'd0 : cap_next[i];
                if (accept) begin
                    drain_buf[i] <= cap_next[i];
                end
            end
        end
    end

    logic [CNT_BITS-1:0]  drain_idx;
    logic [ADDR_BITS-1:0] drain_row;
    logic                 drain_half;
    logic [COL_BITS-1:0]  drain_col;
    logic                 last_write;

    assign drain_half = (drain_idx >= W_CNT);
    assign drain_col  = drain_half ? COL_BITS'(drain_idx - W_CNT) : drain_idx[COL_BITS-1:0];
    assign last_write = wr_en && wr_half && (wr_col == LAST_COL);

    // Drain FSM: replays half 0 then half 1 column by column; also owns status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            drain_idx   <= '0;
            drain_row   <= '0;
            wr_en       <= 1'b0;
            wr_half     <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            wr_rgb      <= '0;
            row_done    <= 1'b0;
            frame_done  <= 1'b0;
            panel_blank <= 1'b1;
            count_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            panel_blank <= s_blank;
            if (latch_rise && cnt_next != W_CNT) begin
                count_err <= 1'b1;
            end
            if (latch_rise && state == DRAIN) begin
                overrun <= 1'b1;
            end
            row_done   <= last_write;
            frame_done <= last_write && (wr_row == '1);
            wr_en      <= 1'b0;
            case (state)
                IDLE: begin
                    if (latch_rise) begin
                        state     <= DRAIN;
                        drain_idx <= '0;
                        drain_row <= s_addr;
                    end
                end
                DRAIN: begin
                    wr_en     <= 1'b1;
                    wr_half   <= drain_half;
                    wr_col    <= drain_col;
                    wr_row    <= drain_row;
                    wr_rgb    <= drain_half ? drain_buf[drain_col][5:3] : drain_buf[drain_col][2:0];
                    drain_idx <= drain_idx + CNT_BITS'(1);
                    if (drain_idx == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - directed self-checking bench for hub75_capture
module tb_hub75_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_rgb0, in_rgb1;
    logic [4:0] in_addr;
    logic       in_blank, in_latch, in_sclk;
    logic       wr_en, wr_half, row_done, frame_done, panel_blank, count_err, overrun;
    logic [4:0] wr_row;
    logic [5:0] wr_col;
    logic [2:0] wr_rgb;

    hub75_capture #(.WIDTH(64), .ADDR_BITS(5), .COL_BITS(6)) dut (
        .clk(clk), .reset(reset),
        .in_rgb0(in_rgb0), .in_rgb1(in_rgb1), .in_addr(in_addr),
        .in_blank(in_blank), .in_latch(in_latch), .in_sclk(in_sclk),
        .wr_en(wr_en), .wr_half(wr_half), .wr_row(wr_row), .wr_col(wr_col), .wr_rgb(wr_rgb),
        .row_done(row_done), .frame_done(frame_done), .panel_blank(panel_blank),
        .count_err(count_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0] mem   [2][32][64];
    logic [2:0] exp_m [2][32][64];
    int wr_cnt = 0, rd_cnt = 0, fd_cnt = 0, fd_row = -1;
    int cyc_p = 0, first_wr_cyc = 0, lat_cyc = 0;

    always @(posedge clk) cyc_p++;

    // Write recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt == 0) first_wr_cyc = cyc_p;
            mem[wr_half][wr_row][wr_col] = wr_rgb;
            wr_cnt++;
        end
        if (row_done) rd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_row = int'(wr_row);
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic shift(input logic [2:0] a, input logic [2:0] b);
        in_rgb0 = a;
        in_rgb1 = b;
        in_sclk = 1'b0;
        repeat (2) step();
        in_sclk = 1'b1;
        repeat (2) step();
    endtask

    task automatic latch(input logic [4:0] a);
        in_addr  = a;
        in_latch = 1'b1;
        lat_cyc  = cyc_p;
        repeat (2) step();
        in_latch = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_done(input int n_rd);
        int t = 0;
        while (rd_cnt < n_rd && t < 400) begin
            step();
            t++;
        end
        chk("drain_timeout", int'(rd_cnt >= n_rd), 1);
        repeat (4) step();
    endtask

    task automatic do_reset();
        in_sclk  = 1'b0;
        in_latch = 1'b0;
        reset    = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic clr();
        for (int h = 0; h < 2; h++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 64; c++) begin
                    mem[h][r][c]   = 3'bxxx;
                    exp_m[h][r][c] = 3'bxxx;
                end
        wr_cnt = 0;
        rd_cnt = 0;
        fd_cnt = 0;
        fd_row = -1;
    endtask

    function automatic int mism(input int row);
        int n = 0;
        for (int h = 0; h < 2; h++)
            for (int c = 0; c < 64; c++)
                if (mem[h][row][c] !== exp_m[h][row][c]) n++;
        return n;
    endfunction

    initial begin
        logic [5:0] cc;
        logic [2:0] a, b;
        int tot;

        reset = 1'b1; in_rgb0 = '0; in_rgb1 = '0; in_addr = '0;
        in_blank = 1'b0; in_latch = 1'b0; in_sclk = 1'b0;
        clr();
        repeat (3) step();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_row_done", int'(row_done), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_count_err", int'(count_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_panel_blank", int'(panel_blank), 1);
        chk("rst_wr_col", int'(wr_col), 0);
        chk("rst_wr_row", int'(wr_row), 0);
        reset = 1'b0;
        repeat (3) step();

        // Patterned row on address 5
        for (int c = 0; c < 64; c++) begin
            cc = 6'(c);
            exp_m[0][5][c] = cc[2:0];
            exp_m[1][5][c] = ~cc[2:0];
            shift(cc[2:0], ~cc[2:0]);
        end
        latch(5'd5);
        wait_done(1);
        chk("t1_writes", wr_cnt, 128);
        chk("t1_mismatch", mism(5), 0);
        chk("t1_row_done", rd_cnt, 1);
        chk("t1_frame_done", fd_cnt, 0);
        chk("t1_latency", first_wr_cyc - lat_cyc, 4);
        chk("t1_count_err", int'(count_err), 0);
        chk("t1_overrun", int'(overrun), 0);
        chk("t1_panel_blank", int'(panel_blank), 0);

        // Full frame of random rows
        clr();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 64; c++) begin
                a = 3'($urandom_range(0, 7));
                b = 3'($urandom_range(0, 7));
                exp_m[0][r][c] = a;
                exp_m[1][r][c] = b;
                shift(a, b);
            end
            latch(5'(r));
            wait_done(r + 1);
        end
        tot = 0;
        for (int r = 0; r < 32; r++) tot += mism(r);
        chk("t2_writes", wr_cnt, 4096);
        chk("t2_mismatch", tot, 0);
        chk("t2_row_done", rd_cnt, 32);
        chk("t2_frame_done", fd_cnt, 1);
        chk("t2_frame_row", fd_row, 31);
        chk("t2_count_err", int'(count_err), 0);

        // Short row then long row
        clr();
        for (int c = 0; c < 64; c++) begin
            a = 3'((c % 7) + 1);
            b = 3'(((c * 3) % 7) + 1);
            exp_m[0][3][c] = (c < 60) ? a : 3'd0;
            exp_m[1][3][c] = (c < 60) ? b : 3'd0;
            if (c < 60) shift(a, b);
        end
        latch(5'd3);
        wait_done(1);
        chk("t3_count_err_short", int'(count_err), 1);
        chk("t3_short_mismatch", mism(3), 0);
        for (int c = 0; c < 70; c++) begin
            a = 3'(((c * 5) % 7) + 1);
            b = 3'((c % 5) + 2);
            if (c < 64) begin
                exp_m[0][4][c] = a;
                exp_m[1][4][c] = b;
            end
            shift(a, b);
        end
        latch(5'd4);
        wait_done(2);
        chk("t3_long_mismatch", mism(4), 0);
        chk("t3_count_err_sticky", int'(count_err), 1);

        // Overrun: second latch while draining
        do_reset();
        chk("t4_rst_count_err", int'(count_err), 0);
        clr();
        for (int c = 0; c < 64; c++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            exp_m[0][7][c] = a;
            exp_m[1][7][c] = b;
            shift(a, b);
        end
        latch(5'd7);
        repeat (16) step();
        latch(5'd9);
        wait_done(1);
        repeat (150) step();
        chk("t4_writes", wr_cnt, 128);
        chk("t4_mismatch", mism(7), 0);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_row_done", rd_cnt, 1);

        // Last shift coincident with latch
        do_reset();
        clr();
        for (int c = 0; c < 64; c++) begin
            a = 3'((c % 6) + 1);
            b = 3'(7 - (c % 5));
            exp_m[0][2][c] = a;
            exp_m[1][2][c] = b;
            if (c < 63) shift(a, b);
        end
        in_rgb0 = a;
        in_rgb1 = b;
        in_sclk = 1'b0;
        repeat (2) step();
        in_sclk  = 1'b1;
        in_addr  = 5'd2;
        in_latch = 1'b1;
        repeat (2) step();
        in_latch = 1'b0;
        repeat (2) step();
        wait_done(1);
        chk("t5_col63_h0", int'(mem[0][2][63]), int'(a));
        chk("t5_col63_h1", int'(mem[1][2][63]), int'(b));
        chk("t5_mismatch", mism(2), 0);
        chk("t5_count_err", int'(count_err), 0);

        // Reset in the middle of a drain
        clr();
        for (int c = 0; c < 64; c++) shift(3'(c), 3'(c + 3));
        latch(5'd6);
        tot = 0;
        while (wr_cnt < 40 && tot < 300) begin
            step();
            tot++;
        end
        reset   = 1'b1;
        in_sclk = 1'b0;
        step();
        chk("t6_wr_en_off", int'(wr_en), 0);
        step();
        chk("t6_count_err", int'(count_err), 0);
        chk("t6_overrun", int'(overrun), 0);
        chk("t6_panel_blank", int'(panel_blank), 1);
        reset = 1'b0;
        repeat (200) step();
        chk("t6_writes", wr_cnt, 40);
        chk("t6_no_row_done", rd_cnt, 0);
        clr();
        for (int c = 0; c < 64; c++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            exp_m[0][8][c] = a;
            exp_m[1][8][c] = b;
            shift(a, b);
        end
        latch(5'd8);
        wait_done(1);
        chk("t6_clean_writes", wr_cnt, 128);
        chk("t6_clean_mismatch", mism(8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Panel-side receiver for the HUB75-style interface our LED driver produces: rgb0/rgb1, row address, blank, latch and sclk.
- Oversamples the pins in the system clock domain and reassembles each shifted row.
- On latch, replays the row as a column-ordered pixel write stream into a frame memory.
- Used for loopback self-test on a second PMOD and as the bench checker for the driver.

Parameters:
- WIDTH, 64, columns shifted per row.
- ADDR_BITS, 5, row address width; rows per half = 2**ADDR_BITS.
- COL_BITS, 6, column index width; must satisfy 2**COL_BITS >= WIDTH.

Ports:
- clk  in  1  system clock, same clock as the driver's pll_clk domain.
- reset  in  1  synchronous, active-high reset.
- in_rgb0  in  3  upper-half pixel bits {b,g,r} as seen on the pins.
- in_rgb1  in  3  lower-half pixel bits.
- in_addr  in  ADDR_BITS  row address pins.
- in_blank  in  1  blank pin.
- in_latch  in  1  latch pin.
- in_sclk  in  1  shift clock pin.
- wr_en  out  1  pixel write strobe.
- wr_half  out  1  0 = rgb0 half, 1 = rgb1 half.
- wr_row  out  ADDR_BITS  row of current write.
- wr_col  out  COL_BITS  column of current write.
- wr_rgb  out  3  pixel value.
- row_done  out  1  one-cycle pulse after last write of a row.
- frame_done  out  1  one-cycle pulse coincident with row_done when wr_row == 2**ADDR_BITS-1.
- panel_blank  out  1  synchronized blank level.
- count_err  out  1  sticky; a latch arrived with shift count != WIDTH.
- overrun  out  1  sticky; a latch arrived while draining.

Behaviour:
- All inputs pass through a 2-flop synchronizer; all bits share identical delay.
- sclk rise = sync sclk 1 while previous sync sample 0. Latch rise detected the same way.
- Input constraint: sclk high and low each >= 2 clk cycles; rgb stable around the sclk rise.
- Capture:
  - On sclk rise with shift_cnt < WIDTH: write sync rgb0/rgb1 (same sample stage as the sclk high sample) into capture buffer entry shift_cnt, then increment shift_cnt.
  - The k-th sclk rise after a latch maps to column k.
  - sclk rises beyond WIDTH are ignored and do not wrap; the resulting count mismatch is flagged on the next latch.
- Latch rise:
  - Set count_err if shift_cnt != WIDTH.
  - If idle: copy capture buffer to drain buffer, capture sync addr as the row, clear capture buffer to 0, set shift_cnt to 0, enter DRAIN next cycle.
  - If in DRAIN: set overrun, drop this latch (no copy, no row change), still clear capture buffer and set shift_cnt to 0.
- Simultaneous sclk rise and latch rise in the same cycle: the sclk sample belongs to the row being latched and is stored before the copy.
- FSM:
  - IDLE -> DRAIN on accepted latch.
  - DRAIN: wr_en high for exactly 2*WIDTH consecutive cycles: half 0 cols 0..WIDTH-1, then half 1 cols 0..WIDTH-1.
  - DRAIN -> IDLE after the last write. row_done (and frame_done if applicable) pulses the cycle after the last wr_en.
  - Latency: first wr_en 1 cycle after latch-rise detection, i.e. 4 clk after the pin edge.
  - Capture continues in parallel during DRAIN.
- panel_blank follows sync blank; it has no effect on capture.
- Reset values:
  - wr_en, row_done, frame_done, count_err, overrun = 0.
  - panel_blank = 1.
  - wr_half/wr_row/wr_col/wr_rgb = 0.
  - Buffers = 0, shift_cnt = 0, FSM = IDLE, synchronizers = 0.
- Reset mid-DRAIN aborts immediately: no further wr_en, no row_done.
- Sticky flags clear only on reset.

Test Plan:
- Shift 64 columns with rgb0 = col[2:0], rgb1 = ~col[2:0], addr = 5, then latch -> 128 wr_en cycles; half0 col c carries c[2:0], half1 carries ~c[2:0]; wr_row = 5; one row_done; flags stay 0.
- Drive 32 rows, addr 0..31, random data -> exactly one frame_done, on row 31; all 4096 writes match the model.
- Shift 60 columns then latch -> count_err = 1; cols 60..63 written as 0. Next row with 70 sclks -> cols 0..63 hold the first 64 samples; count_err remains 1.
- Second latch 20 cycles after the first -> overrun = 1; exactly 128 writes, all with the first row's data and address.
- sclk rise and latch rise in the same synchronized cycle, as the 64th shift -> column 63 holds that sample; count_err = 0.
- Assert reset at write 40 of a drain -> wr_en low the next cycle; no row_done; all flags 0; panel_blank = 1; a subsequent clean row captures correctly.
